frequency_sweep: RTL and testbench
==================================

FREQUENCY_SWEEP -- requirements
Module: frequency_sweep

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting the width of the frequency (phase-increment) words.
REQ-002 The block SHALL have parameter DWELL_WIDTH, default 16, setting the width of the dwell count.
REQ-003 The block SHALL have port ipClk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port ipReset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port ipStart, input, 1 bit: a sweep request, sampled only in IDLE.
REQ-006 The block SHALL have port ipAbort, input, 1 bit: terminates any sweep and returns to IDLE.
REQ-007 The block SHALL have port ipStartFreq, input, WIDTH bits: unsigned first frequency word.
REQ-008 The block SHALL have port ipStopFreq, input, WIDTH bits: unsigned final frequency word.
REQ-009 The block SHALL have port ipStep, input, WIDTH bits: unsigned step magnitude.
REQ-010 The block SHALL have port ipDwell, input, DWELL_WIDTH bits: cycles each frequency is held; the value 0 is treated as 1.
REQ-011 The block SHALL have port opFrequency, output, WIDTH bits: a registered frequency word that drives the NCO ipFrequency input directly.
REQ-012 The block SHALL have port opBusy, output, 1 bit: high while a sweep is in progress.
REQ-013 The block SHALL have port opDone, output, 1 bit: a one-cycle pulse on normal sweep completion.

Function
REQ-014 The block SHALL implement states IDLE, SWEEP and LAST.
REQ-015 In IDLE with ipStart=1 and ipAbort=0, the block SHALL latch all four configuration inputs and, on the next cycle, present opFrequency=ipStartFreq with opBusy=1.
REQ-016 The block SHALL ignore ipStart outside IDLE; configuration changes made mid-sweep SHALL have no effect.
REQ-017 The sweep direction SHALL be up when stop is greater than or equal to start, and down otherwise.
REQ-018 Each frequency value SHALL be held for exactly max(dwell,1) cycles; this is counted by a dwell counter that reloads on every step.
REQ-019 At the end of each dwell, the next value SHALL be current plus step (up) or current minus step (down), computed in WIDTH+1 bits.
REQ-020 If the next value reaches or passes stop, the block SHALL clamp it to stop and enter LAST; no wrap-around is permitted.
REQ-021 If step is 0, the block SHALL move from start directly to stop after one dwell.
REQ-022 If start equals stop, the block SHALL enter LAST immediately and hold stop for one dwell.
REQ-023 When the LAST dwell expires, the next cycle SHALL have opDone=1 for exactly one cycle, opBusy=0 and state IDLE, with opFrequency holding stop.
REQ-024 ipAbort=1 in any state SHALL cause the next cycle to be IDLE with opBusy=0, opDone=0 and opFrequency holding its current value.
REQ-025 When ipStart and ipAbort are asserted together in IDLE, abort SHALL win and no sweep starts.
REQ-026 In IDLE, opFrequency SHALL retain its last value, so the NCO keeps running.

Reset
REQ-027 With ipReset_n=0 at a clock edge, the next cycle SHALL have state IDLE, opFrequency=0, opBusy=0, opDone=0 and the dwell counter at 0.
REQ-028 Reset asserted mid-sweep SHALL override all other inputs, and no opDone SHALL be produced.
REQ-029 After reset deasserts, the block SHALL accept ipStart on the first cycle.

Configuration
REQ-030 When the macro FREQUENCY_SWEEP_CONTINUOUS_EN is defined, expiry of the LAST dwell SHALL reload the latched start value and return to SWEEP, repeating indefinitely; opDone SHALL pulse once per completed pass and opBusy SHALL stay 1 until ipAbort.
REQ-031 When the macro FREQUENCY_SWEEP_CONTINUOUS_EN is not defined, the block SHALL perform a single pass and then return to IDLE per REQ-023.

Verification
REQ-032 The bench SHALL cover an up sweep: start=100, stop=130, step=10, dwell=2 -> opFrequency 100,100,110,110,120,120,130,130; then opDone for one cycle; opBusy high for exactly 8 cycles.
REQ-033 The bench SHALL cover overshoot clamping: start=0, stop=25, step=10, dwell=0 -> 0,10,20,25, one cycle each; then opDone.
REQ-034 The bench SHALL cover a down sweep: start=1000, stop=990, step=4, dwell=3 -> 1000, 996, 992, 990, three cycles each; then opDone.
REQ-035 The bench SHALL cover mid-sweep abort and reset: ipAbort asserted in REQ-032 during the 110 dwell -> next cycle opBusy=0, opFrequency=110, no opDone; ipReset_n=0 during a sweep -> opFrequency=0 next cycle.
REQ-036 The bench SHALL cover edge cases: start=stop=500 with dwell=4 -> 500 for 4 cycles then opDone; ipStart together with ipAbort in IDLE -> opBusy stays 0.
REQ-037 The bench SHALL cover continuous mode with FREQUENCY_SWEEP_CONTINUOUS_EN defined: the REQ-032 stimulus -> 100..130 repeating, opDone pulsing every 8 cycles, opBusy continuously 1 until ipAbort.

Source files
------------

// File: rtl/frequency_sweep.sv
// Stepped frequency sweep controller feeding an NCO phase-increment word.
// Define FREQUENCY_SWEEP_CONTINUOUS_EN to repeat the sweep until aborted.
module frequency_sweep #(
    parameter int WIDTH       = 32,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   ipClk,
    input  logic                   ipReset_n,
    input  logic                   ipStart,
    input  logic                   ipAbort,
    input  logic [WIDTH-1:0]       ipStartFreq,
    input  logic [WIDTH-1:0]       ipStopFreq,
    input  logic [WIDTH-1:0]       ipStep,
    input  logic [DWELL_WIDTH-1:0] ipDwell,
    output logic [WIDTH-1:0]       opFrequency,
    output logic                   opBusy,
    output logic                   opDone
);

    // state | meaning
    // IDLE  | waiting for ipStart, opFrequency held
    // SWEEP | stepping toward stop, one dwell per value
    // LAST  | holding stop for the final dwell
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        LAST  = 2'd2
    } state_t;

    state_t                 state;
    logic [WIDTH-1:0]       startQ;
    logic [WIDTH-1:0]       stopQ;
    logic [WIDTH-1:0]       stepQ;
    logic [DWELL_WIDTH-1:0] dwellReload;
    logic                   dirUp;
    logic [DWELL_WIDTH-1:0] dwellCnt;

    logic [DWELL_WIDTH-1:0] dwellLoad;
    logic [WIDTH:0]         sumUp;
    logic [WIDTH:0]         sumDown;
    logic                   reachStop;
    logic [WIDTH-1:0]       nextFreq;
    logic                   dwellExpired;

    // Dwell of 0 behaves as 1; the counter runs from dwell-1 down to 0.
    always_comb begin
        dwellLoad = '0;
        if (ipDwell != '0) begin
            dwellLoad = ipDwell - DWELL_WIDTH'(1);
        end
    end

    assign dwellExpired = (dwellCnt == '0);

    // One extra bit so a step past either end of the range is seen, never wrapped.
    always_comb begin
        sumUp     = {1'b0, opFrequency} + {1'b0, stepQ};
        sumDown   = {1'b0, opFrequency} - {1'b0, stepQ};
        reachStop = 1'b0;
        nextFreq  = stopQ;
        if (stepQ == '0) begin
            reachStop = 1'b1;
        end else if (dirUp) begin
            reachStop = (sumUp >= {1'b0, stopQ});
        end else begin
            reachStop = sumDown[WIDTH] || (sumDown[WIDTH-1:0] <= stopQ);
        end
        if (!reachStop) begin
            nextFreq = dirUp ? sumUp[WIDTH-1:0] : sumDown[WIDTH-1:0];
        end
    end

    always_ff @(posedge ipClk) begin
        if (!ipReset_n) begin
            state       <= IDLE;
            startQ      <= '0;
            stopQ       <= '0;
            stepQ       <= '0;
            dwellReload <= '0;
            dirUp       <= 1'b0;
            dwellCnt    <= '0;
            opFrequency <= '0;
            opBusy      <= 1'b0;
            opDone      <= 1'b0;
        end else begin
            opDone <= 1'b0;
            if (ipAbort) begin
                state  <= IDLE;
                opBusy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ipStart) begin
                            startQ      <= ipStartFreq;
                            stopQ       <= ipStopFreq;
                            stepQ       <= ipStep;
                            dwellReload <= dwellLoad;
                            dirUp       <= (ipStopFreq >= ipStartFreq);
                            dwellCnt    <= dwellLoad;
                            opFrequency <= ipStartFreq;
                            opBusy      <= 1'b1;
                            state       <= (ipStartFreq == ipStopFreq) ? LAST : SWEEP;
                        end
                    end
                    SWEEP: begin
                        if (dwellExpired) begin
                            opFrequency <= nextFreq;
                            dwellCnt    <= dwellReload;
                            if (reachStop) begin
                                state <= LAST;
                            end
                        end else begin
                            dwellCnt <= dwellCnt - DWELL_WIDTH'(1);
                        end
                    end
                    LAST: begin
                        if (dwellExpired) begin
                            opDone <= 1'b1;
`ifdef FREQUENCY_SWEEP_CONTINUOUS_EN
                            opFrequency <= startQ;
                            dwellCnt    <= dwellReload;
                            state       <= (startQ == stopQ) ? LAST : SWEEP;
`else
                            opBusy <= 1'b0;
                            state  <= IDLE;
`endif
                        end else begin
                            dwellCnt <= dwellCnt - DWELL_WIDTH'(1);
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        opBusy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frequency_sweep.sv
// Testbench for frequency_sweep: table-driven sweeps plus abort/reset/continuous sequences.
module tb_frequency_sweep;

    logic        ipClk = 1'b0;
    logic        ipReset_n;
    logic        ipStart;
    logic        ipAbort;
    logic [31:0] ipStartFreq;
    logic [31:0] ipStopFreq;
    logic [31:0] ipStep;
    logic [15:0] ipDwell;
    logic [31:0] opFrequency;
    logic        opBusy;
    logic        opDone;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]      startF;
        logic [31:0]      stopF;
        logic [31:0]      step;
        logic [15:0]      dwell;
        int               hold;
        int               nVals;
        logic [3:0][31:0] vals;
    } vec_t;

    typedef struct {
        logic [31:0] freq;
        logic        busy;
        logic        done;
    } exp_t;

    vec_t vecs[7];
    exp_t expQ[$];

    frequency_sweep #(.WIDTH(32), .DWELL_WIDTH(16)) dut (
        .ipClk       (ipClk),
        .ipReset_n   (ipReset_n),
        .ipStart     (ipStart),
        .ipAbort     (ipAbort),
        .ipStartFreq (ipStartFreq),
        .ipStopFreq  (ipStopFreq),
        .ipStep      (ipStep),
        .ipDwell     (ipDwell),
        .opFrequency (opFrequency),
        .opBusy      (opBusy),
        .opDone      (opDone)
    );

    always #5 ipClk = ~ipClk;

    function automatic vec_t mkVec(input logic [31:0] s, input logic [31:0] p,
                                   input logic [31:0] st, input logic [15:0] d,
                                   input int hold, input int n,
                                   input logic [31:0] a0, input logic [31:0] a1,
                                   input logic [31:0] a2, input logic [31:0] a3);
        vec_t v;
        v.startF = s;  v.stopF = p;  v.step = st;  v.dwell = d;
        v.hold = hold; v.nVals = n;
        v.vals[0] = a0; v.vals[1] = a1; v.vals[2] = a2; v.vals[3] = a3;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] f, input logic b, input logic d);
        exp_t e;
        e.freq = f; e.busy = b; e.done = d;
        expQ.push_back(e);
    endtask

    // Drive a start request; returns at the negedge of the first sweep cycle.
    task automatic launch(input logic [31:0] s, input logic [31:0] p,
                          input logic [31:0] st, input logic [15:0] d);
        @(negedge ipClk);
        ipStartFreq = s; ipStopFreq = p; ipStep = st; ipDwell = d;
        ipStart = 1'b1;
        @(negedge ipClk);
        ipStart     = 1'b0;
        ipStartFreq = $urandom;
        ipStopFreq  = $urandom;
        ipStep      = $urandom;
        ipDwell     = 16'($urandom);
    endtask

    // Pop and compare one expectation per cycle; optional one-cycle abort/start pulses.
    task automatic drain(input string tag, input int abortAt, input int startAt, output int busyN);
        exp_t e;
        int   k;
        k = 0;
        busyN = 0;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            check({tag, " freq"}, opFrequency, e.freq);
            check({tag, " busy"}, 32'(opBusy), 32'(e.busy));
            check({tag, " done"}, 32'(opDone), 32'(e.done));
            if (opBusy) busyN++;
            ipAbort = (k == abortAt);
            ipStart = (k == startAt);
            k++;
            @(negedge ipClk);
        end
        ipAbort = 1'b0;
        ipStart = 1'b0;
    endtask

    initial begin
        int busyN;
        ipReset_n = 1'b0; ipStart = 1'b0; ipAbort = 1'b0;
        ipStartFreq = 32'd0; ipStopFreq = 32'd0; ipStep = 32'd0; ipDwell = 16'd0;

        vecs[0] = mkVec(32'd100,  32'd130, 32'd10, 16'd2, 2, 4, 32'd100,  32'd110, 32'd120, 32'd130);
        vecs[1] = mkVec(32'd0,    32'd25,  32'd10, 16'd0, 1, 4, 32'd0,    32'd10,  32'd20,  32'd25);
        vecs[2] = mkVec(32'd1000, 32'd990, 32'd4,  16'd3, 3, 4, 32'd1000, 32'd996, 32'd992, 32'd990);
        vecs[3] = mkVec(32'd500,  32'd500, 32'd7,  16'd4, 4, 1, 32'd500,  32'd0,   32'd0,   32'd0);
        vecs[4] = mkVec(32'd5,    32'd50,  32'd0,  16'd2, 2, 2, 32'd5,    32'd50,  32'd0,   32'd0);
        vecs[5] = mkVec(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 16'd1, 1, 2,
                        32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd0, 32'd0);
        vecs[6] = mkVec(32'd5,    32'd0,   32'd10, 16'd1, 1, 2, 32'd5,    32'd0,   32'd0,   32'd0);

        repeat (3) @(negedge ipClk);
        check("reset freq", opFrequency, 32'd0);
        check("reset busy", 32'(opBusy), 32'd0);
        check("reset done", 32'(opDone), 32'd0);

        // Start on the very first cycle out of reset.
        ipReset_n   = 1'b1;
        ipStartFreq = 32'd100; ipStopFreq = 32'd130; ipStep = 32'd10; ipDwell = 16'd2;
        ipStart     = 1'b1;
        @(negedge ipClk);
        ipStart = 1'b0;
        check("post-reset start freq", opFrequency, 32'd100);
        check("post-reset start busy", 32'(opBusy), 32'd1);

        // Reset in the middle of that sweep: freq zeroed, no done ever.
        @(negedge ipClk);
        ipReset_n = 1'b0;
        @(negedge ipClk);
        check("mid reset freq", opFrequency, 32'd0);
        check("mid reset busy", 32'(opBusy), 32'd0);
        repeat (8) begin
            @(negedge ipClk);
            check("mid reset done", 32'(opDone), 32'd0);
        end
        ipReset_n = 1'b1;
        for (int i = 0; i < 4; i++) push(32'd0, 1'b0, 1'b0);
        drain("after reset", -1, -1, busyN);

        // Mid-sweep abort during the 110 dwell.
        launch(32'd100, 32'd130, 32'd10, 16'd2);
        push(32'd100, 1'b1, 1'b0);
        push(32'd100, 1'b1, 1'b0);
        push(32'd110, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) push(32'd110, 1'b0, 1'b0);
        drain("abort", 2, -1, busyN);

        // Start and abort together in IDLE: nothing starts.
        @(negedge ipClk);
        ipStartFreq = 32'd777; ipStopFreq = 32'd900; ipStep = 32'd1; ipDwell = 16'd1;
        ipStart = 1'b1; ipAbort = 1'b1;
        @(negedge ipClk);
        ipStart = 1'b0; ipAbort = 1'b0;
        for (int i = 0; i < 4; i++) push(32'd110, 1'b0, 1'b0);
        drain("start+abort", -1, -1, busyN);

`ifdef FREQUENCY_SWEEP_CONTINUOUS_EN
        launch(32'd100, 32'd130, 32'd10, 16'd2);
        for (int pass = 0; pass < 3; pass++) begin
            for (int v = 0; v < 4; v++) begin
                for (int h = 0; h < 2; h++) begin
                    push(32'd100 + 32'(10 * v), 1'b1, (pass > 0 && v == 0 && h == 0));
                end
            end
        end
        push(32'd100, 1'b1, 1'b1);
        push(32'd100, 1'b0, 1'b0);
        push(32'd100, 1'b0, 1'b0);
        drain("continuous", 24, -1, busyN);
        check("continuous busy cycles", 32'(busyN), 32'd25);
`else
        for (int i = 0; i < 7; i++) begin
            launch(vecs[i].startF, vecs[i].stopF, vecs[i].step, vecs[i].dwell);
            for (int v = 0; v < vecs[i].nVals; v++) begin
                for (int h = 0; h < vecs[i].hold; h++) push(vecs[i].vals[v], 1'b1, 1'b0);
            end
            push(vecs[i].stopF, 1'b0, 1'b1);
            push(vecs[i].stopF, 1'b0, 1'b0);
            drain($sformatf("vec%0d", i), -1, 1, busyN);
            check($sformatf("vec%0d busy cycles", i), 32'(busyN), 32'(vecs[i].hold * vecs[i].nVals));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
